// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: data width, bubble encoding, reset vector and fetch FSM encoding.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [0:0] FETCH_RUN   = 1'b0;
    localparam logic [0:0] FETCH_FAULT = 1'b1;

    function automatic logic misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch stage's memory, redirect, decode-handshake and fault signals.
interface instruction_fetch_unit_if;
    import rv32i_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            id_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_plus4;
    logic            fetch_fault;
    logic [XLEN-1:0] fault_pc;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_target,
        input  id_ready,
        output id_valid,
        output id_instr,
        output id_pc,
        output id_pc_plus4,
        output fetch_fault,
        output fault_pc
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_target,
        output id_ready,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        input  id_pc_plus4,
        input  fetch_fault,
        input  fault_pc
    );

endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: instruction, its PC and PC+4, plus a valid bit.
module if_id_register
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE = rv32i_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic            drop,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

    // Flush wins over load; drop only retires the valid bit and leaves the payload.
    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = BUBBLE;
        end else if (load) begin
            valid_d    = 1'b1;
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_i + 32'd4;
        end else if (drop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= BUBBLE;
            pc_q       <= '0;
            pc_plus4_q <= '0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: owns the PC, selects the next PC, captures into IF/ID and tracks a sticky fetch fault.
module instruction_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     IMEM_WORDS = 16,
    parameter logic [XLEN-1:0] NOP_INSTR  = rv32i_pkg::NOP_INSTR
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_unit_if.master  bus
);

    // 33-bit window bounds so RESET_PC near 2^32 cannot wrap the comparison.
    localparam logic [XLEN:0] WINDOW_LO = {1'b0, RESET_PC};
    localparam logic [XLEN:0] WINDOW_HI = WINDOW_LO + 33'(4 * IMEM_WORDS) - 33'd4;

    function automatic logic in_range(input logic [XLEN-1:0] a);
        return ({1'b0, a} >= WINDOW_LO) && ({1'b0, a} <= WINDOW_HI);
    endfunction

    logic [XLEN-1:0] pc_q, pc_d;
    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;

    logic            id_valid;
    logic            slot_free;
    logic            load, flush, drop;

    assign slot_free = !id_valid || bus.id_ready;

    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        fault_pc_d = fault_pc_q;
        load       = 1'b0;
        flush      = 1'b0;
        drop       = 1'b0;
        if (state_q == FETCH_RUN) begin
            if (bus.redirect_valid) begin
                flush = 1'b1;
                if (misaligned(bus.redirect_target[1:0]) || !in_range(bus.redirect_target)) begin
                    state_d    = FETCH_FAULT;
                    fault_pc_d = bus.redirect_target;
                end else begin
                    pc_d = bus.redirect_target;
                end
            end else if (slot_free && !in_range(pc_q)) begin
                state_d    = FETCH_FAULT;
                fault_pc_d = pc_q;
                drop       = 1'b1;
            end else if (slot_free) begin
                load = 1'b1;
                pc_d = pc_q + 32'd4;
            end
        end else begin
            // Faulted: PC frozen and redirects ignored; only let decode drain what it holds.
            drop = id_valid && bus.id_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            state_q    <= FETCH_RUN;
            fault_pc_q <= '0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    if_id_register #(
        .BUBBLE (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .flush      (flush),
        .drop       (drop),
        .instr_i    (bus.imem_instr),
        .pc_i       (pc_q),
        .valid_o    (id_valid),
        .instr_o    (bus.id_instr),
        .pc_o       (bus.id_pc),
        .pc_plus4_o (bus.id_pc_plus4)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.id_valid    = id_valid;
    assign bus.fetch_fault = (state_q == FETCH_FAULT);
    assign bus.fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a cycle-level reference model and literal checkpoints.
module tb_instruction_fetch_unit;

    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam int          T_WORDS    = 16;
    localparam logic [31:0] T_NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC   (T_RESET_PC),
        .IMEM_WORDS (T_WORDS),
        .NOP_INSTR  (T_NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [T_WORDS];

    function automatic bit legal(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la >= longint'(T_RESET_PC)) && (la < longint'(T_RESET_PC) + 4 * T_WORDS);
    endfunction

    function automatic int word_index(input logic [31:0] a);
        return int'((a - T_RESET_PC) >> 2);
    endfunction

    always_comb begin
        bus.imem_instr = 32'hDEAD_BEEF;
        if (legal(bus.imem_addr)) bus.imem_instr = mem[word_index(bus.imem_addr)];
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the architectural rules of the stage, one step per clock edge.
    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_fpc;
    logic        m_valid, m_fault;

    always @(posedge clk) begin
        if (rst) begin
            m_pc <= T_RESET_PC; m_valid <= 1'b0; m_instr <= T_NOP;
            m_idpc <= 32'h0; m_idpc4 <= 32'h0; m_fault <= 1'b0; m_fpc <= 32'h0;
        end else if (m_fault) begin
            if (m_valid && bus.id_ready) m_valid <= 1'b0;
        end else if (bus.redirect_valid) begin
            m_valid <= 1'b0;
            m_instr <= T_NOP;
            if ((bus.redirect_target % 4) != 0 || !legal(bus.redirect_target)) begin
                m_fault <= 1'b1;
                m_fpc   <= bus.redirect_target;
            end else begin
                m_pc <= bus.redirect_target;
            end
        end else if (!m_valid || bus.id_ready) begin
            if (!legal(m_pc)) begin
                m_fault <= 1'b1;
                m_fpc   <= m_pc;
                m_valid <= 1'b0;
            end else begin
                m_instr <= mem[word_index(m_pc)];
                m_idpc  <= m_pc;
                m_idpc4 <= m_pc + 32'd4;
                m_valid <= 1'b1;
                m_pc    <= m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_imem_addr",   bus.imem_addr,            m_pc);
            check("model_id_valid",    {31'b0, bus.id_valid},    {31'b0, m_valid});
            check("model_id_instr",    bus.id_instr,             m_instr);
            check("model_id_pc",       bus.id_pc,                m_idpc);
            check("model_id_pc_plus4", bus.id_pc_plus4,          m_idpc4);
            check("model_fetch_fault", {31'b0, bus.fetch_fault}, {31'b0, m_fault});
            check("model_fault_pc",    bus.fault_pc,             m_fpc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_reset_values(input string tag);
        check({tag, "_id_valid"},    {31'b0, bus.id_valid},    32'h0);
        check({tag, "_id_instr"},    bus.id_instr,             32'h0000_0013);
        check({tag, "_id_pc"},       bus.id_pc,                32'h0);
        check({tag, "_id_pc_plus4"}, bus.id_pc_plus4,          32'h0);
        check({tag, "_fetch_fault"}, {31'b0, bus.fetch_fault}, 32'h0);
        check({tag, "_fault_pc"},    bus.fault_pc,             32'h0);
        check({tag, "_imem_addr"},   bus.imem_addr,            32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] last_pc;
    bit          seen_fault;

    initial begin
        for (int i = 0; i < T_WORDS; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00a0_0113;
        mem[2] = 32'h0020_81b3;

        rst = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.id_ready        = 1'b1;
        tick(); tick();
        expect_reset_values("reset");
        chk_en = 1'b1;
        rst = 1'b0;

        // Sequential fetch
        tick();
        check("seq0_valid", {31'b0, bus.id_valid}, 32'h1);
        check("seq0_instr", bus.id_instr,    32'h0050_0093);
        check("seq0_pc",    bus.id_pc,       32'h0);
        check("seq0_pc4",   bus.id_pc_plus4, 32'h4);
        tick();
        check("seq1_instr", bus.id_instr,    32'h00a0_0113);
        check("seq1_pc",    bus.id_pc,       32'h4);
        check("seq1_pc4",   bus.id_pc_plus4, 32'h8);
        check("seq1_addr",  bus.imem_addr,   32'h8);

        // Stall for three cycles
        bus.id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", {31'b0, bus.id_valid}, 32'h1);
            check("stall_instr", bus.id_instr,  32'h00a0_0113);
            check("stall_pc",    bus.id_pc,     32'h4);
            check("stall_addr",  bus.imem_addr, 32'h8);
        end
        bus.id_ready = 1'b1;
        tick();
        check("resume_instr", bus.id_instr,    32'h0020_81b3);
        check("resume_pc",    bus.id_pc,       32'h8);
        check("resume_pc4",   bus.id_pc_plus4, 32'hC);

        // Redirect to 0x14 while decode is stalled
        bus.id_ready = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h14;
        tick();
        check("redir_valid", {31'b0, bus.id_valid}, 32'h0);
        check("redir_instr", bus.id_instr,  32'h0000_0013);
        check("redir_addr",  bus.imem_addr, 32'h14);
        bus.redirect_valid = 1'b0;
        bus.id_ready = 1'b1;
        tick();
        check("redir_tgt_valid", {31'b0, bus.id_valid}, 32'h1);
        check("redir_tgt_pc",    bus.id_pc,    32'h14);
        check("redir_tgt_instr", bus.id_instr, 32'hA000_0005);

        // Misaligned redirect faults; later redirects are ignored
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h6;
        tick();
        check("misal_fault", {31'b0, bus.fetch_fault}, 32'h1);
        check("misal_fpc",   bus.fault_pc,  32'h6);
        check("misal_valid", {31'b0, bus.id_valid}, 32'h0);
        check("misal_addr",  bus.imem_addr, 32'h18);
        bus.redirect_target = 32'h0;
        tick();
        bus.redirect_valid = 1'b0;
        repeat (3) tick();
        check("sticky_fault", {31'b0, bus.fetch_fault}, 32'h1);
        check("sticky_fpc",   bus.fault_pc,  32'h6);
        check("sticky_addr",  bus.imem_addr, 32'h18);

        // Aligned but out-of-window redirect
        rst = 1'b1; tick(); rst = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h40;
        tick();
        check("oor_fault", {31'b0, bus.fetch_fault}, 32'h1);
        check("oor_fpc",   bus.fault_pc,  32'h40);
        check("oor_addr",  bus.imem_addr, 32'h0);
        bus.redirect_valid = 1'b0;

        // Redirect to the last legal word, then run off the end
        rst = 1'b1; tick(); rst = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h3C;
        tick();
        check("edge_addr",  bus.imem_addr, 32'h3C);
        check("edge_fault", {31'b0, bus.fetch_fault}, 32'h0);
        bus.redirect_valid = 1'b0;
        tick();
        check("edge_pc",    bus.id_pc,    32'h3C);
        check("edge_instr", bus.id_instr, 32'hA000_000F);
        tick();
        check("edge_runoff_fpc", bus.fault_pc, 32'h40);

        // Full sequential run-off from RESET_PC
        rst = 1'b1; tick(); rst = 1'b0;
        last_pc = 32'hFFFF_FFFF;
        seen_fault = 1'b0;
        for (int k = 0; k < 40 && !seen_fault; k++) begin
            tick();
            if (bus.id_valid) last_pc = bus.id_pc;
            seen_fault = bus.fetch_fault;
        end
        check("runoff_fault",   {31'b0, seen_fault}, 32'h1);
        check("runoff_fpc",     bus.fault_pc,  32'h40);
        check("runoff_last_pc", last_pc,       32'h3C);
        check("runoff_valid",   {31'b0, bus.id_valid}, 32'h0);

        // Reset asserted during a stall
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        bus.id_ready = 1'b0;
        tick();
        check("pre_rst_valid", {31'b0, bus.id_valid}, 32'h1);
        rst = 1'b1;
        tick();
        expect_reset_values("midrst");
        rst = 1'b0;
        bus.id_ready = 1'b1;
        tick();
        check("post_rst_valid", {31'b0, bus.id_valid}, 32'h1);
        check("post_rst_pc",    bus.id_pc,    32'h0);
        check("post_rst_instr", bus.id_instr, 32'h0050_0093);
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
